// File: rtl/data_memory_responder.sv
// data_memory_responder: responder end of the MEM-stage data-memory interface.
// One request is accepted at a time over valid/ready. After LATENCY busy cycles
// the access is performed and answered with a single-cycle RespValid pulse.
// All response outputs are registered; ReqReady and Busy come from the state register.
module data_memory_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Lb,
    input  logic        LoadExtended,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        Error,
    output logic        Busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] count;

    logic        req_read;
    logic        req_write;
    logic        req_lb;
    logic        req_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             finish;
    logic             word_access;
    logic             access_error;
    logic [IDX_W-1:0] word_index;
    logic [31:0]      mem_word;
    logic [7:0]       lane_byte;
    logic [31:0]      load_data;

    // A request is only taken when it actually asks for a read or a write.
    assign accept   = (state == IDLE) && ReqValid && (MemRead || MemWrite);
    assign finish   = (state == BUSY) && (count == '0);
    assign ReqReady = (state == IDLE);
    assign Busy     = (state != IDLE);

    assign word_index = req_addr[IDX_W+1:2];
    assign mem_word   = mem[word_index];

    // State register; reset aborts any outstanding request.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP when the countdown hits zero.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = BUSY;
            BUSY:    if (count == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Fault detection and load formatting from the latched request.
    always_comb begin
        word_access  = req_write || !req_lb;
        access_error = (req_read && req_write)
                    || ({1'b0, req_addr} >= MEM_BYTES)
                    || (word_access && (req_addr[1:0] != 2'b00));
        lane_byte = mem_word[7:0];
        case (req_addr[1:0])
            2'd0:    lane_byte = mem_word[7:0];
            2'd1:    lane_byte = mem_word[15:8];
            2'd2:    lane_byte = mem_word[23:16];
            default: lane_byte = mem_word[31:24];
        endcase
        load_data = '0;
        if (!access_error && req_read) begin
            if (req_lb) begin
                load_data = {{24{req_ext & lane_byte[7]}}, lane_byte};
            end else begin
                load_data = mem_word;
            end
        end
    end

    // Request capture at accept; these hold steady until the next accept.
    always_ff @(posedge Clk) begin
        if (accept) begin
            req_read  <= MemRead;
            req_write <= MemWrite;
            req_lb    <= Lb;
            req_ext   <= LoadExtended;
            req_addr  <= Address;
            req_wdata <= WriteData;
        end
    end

    // Busy countdown and the registered response, which is live only during RESP.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count     <= '0;
            RespValid <= 1'b0;
            ReadData  <= '0;
            Error     <= 1'b0;
        end else begin
            if (accept) begin
                count <= CNT_START;
            end else if ((state == BUSY) && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
            RespValid <= finish;
            ReadData  <= finish ? load_data : '0;
            Error     <= finish ? access_error : 1'b0;
        end
    end

    // Storage is never cleared; a write commits only on a clean BUSY->RESP edge.
    always_ff @(posedge Clk) begin
        if (Rst && finish && req_write && !access_error) begin
            mem[word_index] <= req_wdata;
        end
    end

endmodule
